// File: rtl/zfp_pkg.sv
// zfp_pkg - shared helpers for the floating-point block encoder.
//
// Contents:
//   ZFP_MAX_W       widest float word the helpers handle (64 bits).
//   zfp_word_t      container type; narrower formats are zero-extended into it.
//   clog2()         ceiling log2 for sizing counters and pointers.
//   blk_size()      block size rule: 4**dims values per block.
//   field_mask()    low-order mask of a given width.
//   get_expo()      exponent field of a float with (fp_w, exp_w) layout.
//   get_frac()      fraction field of a float with (fp_w, exp_w) layout.
//   exp_contrib()   saturating per-value exponent contribution, shared with
//                   fwd_cast so both stages agree on the block emax.
package zfp_pkg;

  localparam int ZFP_MAX_W = 64;

  typedef logic [ZFP_MAX_W-1:0] zfp_word_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int blk_size(input int dims);
    return 4 ** dims;
  endfunction

  function automatic zfp_word_t field_mask(input int w);
    if (w >= ZFP_MAX_W) return '1;
    return (zfp_word_t'(1) << w) - zfp_word_t'(1);
  endfunction

  // Exponent sits directly below the sign bit, above the fraction.
  function automatic zfp_word_t get_expo(input zfp_word_t v, input int fp_w,
                                         input int exp_w);
    return (v >> (fp_w - 1 - exp_w)) & field_mask(exp_w);
  endfunction

  function automatic zfp_word_t get_frac(input zfp_word_t v, input int fp_w,
                                         input int exp_w);
    return v & field_mask(fp_w - 1 - exp_w);
  endfunction

  // True zero contributes 0 so an all-zero block has emax 0; every other
  // value contributes expo+1, except Inf/NaN which pin at all-ones rather
  // than wrapping back to 0.
  function automatic zfp_word_t exp_contrib(input zfp_word_t expo,
                                            input zfp_word_t frac,
                                            input int exp_w);
    zfp_word_t ones;
    ones = field_mask(exp_w);
    if (expo == '0 && frac == '0) return '0;
    if (expo == ones) return ones;
    return (expo + zfp_word_t'(1)) & ones;
  endfunction

endpackage

// File: rtl/rvfifo_cc.sv
// rvfifo_cc - single-clock ready/valid FIFO.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low flush of pointers/count.
//   s_data/valid/ready  write side; s_ready = not full (no full-bypass).
//   m_data/valid/ready  read side; m_data is the head entry, held stable
//                       while m_valid && !m_ready.
// A write is visible on the read side the cycle after it is accepted.
// DEPTH must be a power of two so the pointers wrap naturally.
module rvfifo_cc
  import zfp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int AW = clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push, pop;

  assign s_ready = (count_q != (AW+1)'(DEPTH));
  assign m_valid = (count_q != '0);
  assign m_data  = mem_q[rd_ptr_q];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and a latch is never inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count gates
  // m_valid, so stale contents are never observed and the array can map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: rtl/find_emax_p.sv
// find_emax_p - block exponent-max stage of the floating-point encoder.
//
// Scans the input stream in blocks of BLK = 4**DIMS values, forwards every
// value unchanged through a DEPTH-entry FIFO, and emits one emax plus an
// all-zero flag per block on an independent handshake.
//
// Ports:
//   clk, reset                clock; synchronous active-low reset.
//   s_fp_data/valid/ready     input value stream.
//   m_fp_data/valid/ready     forwarded values, same order, one cycle latency.
//   m_ex_data/zero/valid/ready  per-block emax and all-zero flag.
module find_emax_p
  import zfp_pkg::*;
#(
  parameter int FP_W  = 64,
  parameter int EXP_W = 11,
  parameter int DIMS  = 2,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [FP_W-1:0]  s_fp_data,
  input  logic             s_fp_valid,
  output logic             s_fp_ready,
  output logic [FP_W-1:0]  m_fp_data,
  output logic             m_fp_valid,
  input  logic             m_fp_ready,
  output logic [EXP_W-1:0] m_ex_data,
  output logic             m_ex_zero,
  output logic             m_ex_valid,
  input  logic             m_ex_ready
);

  localparam int BLK   = blk_size(DIMS);
  localparam int CNT_W = (BLK > 1) ? clog2(BLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] acc_q, acc_d;
  logic             zf_q, zf_d;
  logic             ex_valid_q, ex_valid_d;
  logic [EXP_W-1:0] ex_data_q, ex_data_d;
  logic             ex_zero_q, ex_zero_d;

  logic [EXP_W-1:0] e;
  logic [EXP_W-1:0] acc_next;
  logic             zf_next;
  logic             fifo_ready;
  logic             last;
  logic             accept;

  assign e = EXP_W'(exp_contrib(get_expo(ZFP_MAX_W'(s_fp_data), FP_W, EXP_W),
                                get_frac(ZFP_MAX_W'(s_fp_data), FP_W, EXP_W),
                                EXP_W));

  assign last = (cnt_q == CNT_LAST);

  // Only the block-closing value needs a free emax slot; a slot being
  // drained this very cycle counts as free.
  assign s_fp_ready = reset && fifo_ready &&
                      (!last || !ex_valid_q || m_ex_ready);
  assign accept     = s_fp_valid && s_fp_ready;

  assign m_ex_data  = ex_data_q;
  assign m_ex_zero  = ex_zero_q;
  assign m_ex_valid = ex_valid_q;

  always_comb begin
    // First value of a block starts fresh; with BLK==1 this also yields
    // e alone for the emax.
    if (cnt_q == '0) begin
      acc_next = e;
      zf_next  = (e == '0);
    end else begin
      acc_next = (e > acc_q) ? e : acc_q;
      zf_next  = zf_q && (e == '0);
    end

    cnt_d      = cnt_q;
    acc_d      = acc_q;
    zf_d       = zf_q;
    ex_valid_d = ex_valid_q;
    ex_data_d  = ex_data_q;
    ex_zero_d  = ex_zero_q;

    if (accept) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      acc_d = acc_next;
      zf_d  = zf_next;
    end

    if (ex_valid_q && m_ex_ready) ex_valid_d = 1'b0;
    // Load after clear so a same-cycle load keeps the register valid.
    if (accept && last) begin
      ex_valid_d = 1'b1;
      ex_data_d  = acc_next;
      ex_zero_d  = zf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      zf_q       <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_data_q  <= '0;
      ex_zero_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      zf_q       <= zf_d;
      ex_valid_q <= ex_valid_d;
      ex_data_q  <= ex_data_d;
      ex_zero_q  <= ex_zero_d;
    end
  end

  rvfifo_cc #(
    .WIDTH (FP_W),
    .DEPTH (DEPTH)
  ) u_value_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .s_data  (s_fp_data),
    .s_valid (accept),
    .s_ready (fifo_ready),
    .m_data  (m_fp_data),
    .m_valid (m_fp_valid),
    .m_ready (m_fp_ready)
  );

endmodule

// File: tb/tb_find_emax_p.sv
// tb_find_emax_p - self-checking bench for find_emax_p (FP_W=64, EXP_W=11,
// DIMS=1, DEPTH=8). A transaction-level model (queues of pending values and
// emax results, list of contributions in the open block) predicts every
// handshake and data value cycle by cycle.
module tb_find_emax_p;

  localparam int FP_W  = 64;
  localparam int EXP_W = 11;
  localparam int DIMS  = 1;
  localparam int DEPTH = 8;
  localparam int BLK   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [FP_W-1:0]  s_fp_data;
  logic             s_fp_valid;
  logic             s_fp_ready;
  logic [FP_W-1:0]  m_fp_data;
  logic             m_fp_valid;
  logic             m_fp_ready;
  logic [EXP_W-1:0] m_ex_data;
  logic             m_ex_zero;
  logic             m_ex_valid;
  logic             m_ex_ready;

  find_emax_p #(
    .FP_W  (FP_W),
    .EXP_W (EXP_W),
    .DIMS  (DIMS),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_fp_data  (s_fp_data),
    .s_fp_valid (s_fp_valid),
    .s_fp_ready (s_fp_ready),
    .m_fp_data  (m_fp_data),
    .m_fp_valid (m_fp_valid),
    .m_fp_ready (m_fp_ready),
    .m_ex_data  (m_ex_data),
    .m_ex_zero  (m_ex_zero),
    .m_ex_valid (m_ex_valid),
    .m_ex_ready (m_ex_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int emax;
    bit zero;
  } ex_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          accepted = 0;
  int          ex_taken = 0;
  logic [63:0] mq[$];
  ex_t         eq[$];
  int          blk[$];
  int          last_ex_data = -1;
  bit          last_ex_zero = 1'b0;
  logic        rst_tb = 1'b0;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Exponent contribution straight from the format rules.
  function automatic int contrib(input logic [63:0] v);
    int ex;
    ex = int'(v[62:52]);
    if (ex == 0 && v[51:0] == 52'd0) return 0;
    if (ex == 2047) return 2047;
    return ex + 1;
  endfunction

  function automatic logic [63:0] rand_value();
    logic        sg;
    logic [10:0] ex;
    logic [51:0] fr;
    sg = 1'($urandom);
    fr = {20'($urandom), 32'($urandom)};
    case ($urandom_range(0, 7))
      0, 1: begin ex = '0; fr = '0; end
      2:    begin ex = '0; fr = 52'($urandom_range(0, 3)); end
      3:    begin ex = '1; end
      4:    begin ex = 11'($urandom_range(2040, 2046)); end
      default: ex = 11'($urandom);
    endcase
    return {sg, ex, fr};
  endfunction

  // One clock cycle: drive at the falling edge, compare settled outputs
  // against the model, then advance the model by the handshakes that the
  // coming rising edge will complete.
  task automatic step(input logic sv, input logic [63:0] sd, input logic fr,
                      input logic er, output bit acc);
    bit exp_ready;
    bit fp_hs;
    bit ex_hs;
    ex_t r;
    @(negedge clk);
    reset      = rst_tb;
    s_fp_valid = sv;
    s_fp_data  = sd;
    m_fp_ready = fr;
    m_ex_ready = er;
    #1;
    exp_ready = rst_tb && (mq.size() < DEPTH) &&
                (blk.size() != BLK - 1 || eq.size() == 0 || er);
    check("s_fp_ready", 64'(s_fp_ready), 64'(exp_ready));
    check("m_fp_valid", 64'(m_fp_valid), 64'(mq.size() != 0));
    check("m_ex_valid", 64'(m_ex_valid), 64'(eq.size() != 0));
    acc = 1'b0;
    if (!rst_tb) begin
      mq.delete();
      eq.delete();
      blk.delete();
    end else begin
      fp_hs = (mq.size() != 0) && fr;
      ex_hs = (eq.size() != 0) && er;
      if (fp_hs) begin
        check("m_fp_data", m_fp_data, mq[0]);
        void'(mq.pop_front());
      end
      if (ex_hs) begin
        check("m_ex_data", 64'(m_ex_data), 64'(eq[0].emax));
        check("m_ex_zero", 64'(m_ex_zero), 64'(eq[0].zero));
        last_ex_data = int'(m_ex_data);
        last_ex_zero = m_ex_zero;
        ex_taken++;
        void'(eq.pop_front());
      end
      if (sv && exp_ready) begin
        acc = 1'b1;
        accepted++;
        mq.push_back(sd);
        blk.push_back(contrib(sd));
        if (blk.size() == BLK) begin
          r.emax = 0;
          r.zero = 1'b1;
          foreach (blk[i]) begin
            if (blk[i] > r.emax) r.emax = blk[i];
            if (blk[i] != 0) r.zero = 1'b0;
          end
          eq.push_back(r);
          blk.delete();
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] v, input logic fr, input logic er);
    bit a;
    int tries;
    tries = 0;
    do begin
      step(1'b1, v, fr, er, a);
      tries++;
    end while (!a && tries < 20);
    check("send_accept", 64'(a), 64'(1));
  endtask

  task automatic drain(input int n);
    bit a;
    repeat (n) step(1'b0, 64'd0, 1'b1, 1'b1, a);
  endtask

  initial begin
    bit          a;
    int          acc0;
    int          ex0;
    logic [63:0] v;
    logic [63:0] s1 [4];
    logic [63:0] s4 [8];

    reset      = 1'b0;
    s_fp_valid = 1'b0;
    s_fp_data  = '0;
    m_fp_ready = 1'b0;
    m_ex_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, including outputs while reset is still held.
    rst_tb = 1'b0;
    step(1'b0, 64'd0, 1'b1, 1'b1, a);
    check("rst_ex_data", 64'(m_ex_data), 64'd0);
    check("rst_ex_zero", 64'(m_ex_zero), 64'd0);
    rst_tb = 1'b1;

    // 1: ordinary block, emax 0x402.
    s1[0] = 64'h3FF0_0000_0000_0000;
    s1[1] = 64'h4000_0000_0000_0000;
    s1[2] = 64'h3FE0_0000_0000_0000;
    s1[3] = 64'hC010_0000_0000_0000;
    foreach (s1[i]) send(s1[i], 1'b1, 1'b1);
    drain(4);
    check("s1_emax", 64'(last_ex_data), 64'h402);
    check("s1_zero", 64'(last_ex_zero), 64'd0);

    // 2: all-zero block, then one zero replaced by the smallest denormal.
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h8000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    drain(3);
    check("s2_zero_emax", 64'(last_ex_data), 64'd0);
    check("s2_zero_flag", 64'(last_ex_zero), 64'd1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h8000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0001, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    drain(3);
    check("s2_denorm_emax", 64'(last_ex_data), 64'd1);
    check("s2_denorm_zero", 64'(last_ex_zero), 64'd0);

    // 3: Inf and NaN saturate at all-ones.
    send(64'h3FF0_0000_0000_0000, 1'b1, 1'b1);
    send(64'h7FF0_0000_0000_0000, 1'b1, 1'b1);
    send(64'h4000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    drain(3);
    check("s3_inf_emax", 64'(last_ex_data), 64'h7FF);
    send(64'hFFF8_0000_0000_0001, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 1'b1);
    drain(3);
    check("s3_nan_emax", 64'(last_ex_data), 64'h7FF);

    // 4: emax held across two back-to-back blocks; only the 8th value stalls.
    for (int i = 0; i < 8; i++) s4[i] = rand_value();
    for (int i = 0; i < 7; i++) send(s4[i], 1'b1, 1'b0);
    step(1'b1, s4[7], 1'b1, 1'b0, a);
    check("s4_stall", 64'(a), 64'd0);
    step(1'b1, s4[7], 1'b1, 1'b1, a);
    check("s4_release", 64'(a), 64'd1);
    drain(4);

    // 5: value sink stalled: exactly DEPTH values accepted, emax still flows.
    acc0 = accepted;
    ex0  = ex_taken;
    for (int i = 0; i < 12; i++) begin
      v = rand_value();
      step(1'b1, v, 1'b0, 1'b1, a);
    end
    check("s5_accepted", 64'(accepted - acc0), 64'd8);
    check("s5_emax_cnt", 64'(ex_taken - ex0), 64'd2);
    drain(12);

    // 6: reset mid-block discards the partial block.
    send(64'h7FE0_0000_0000_0000, 1'b1, 1'b1);
    send(64'h7FE0_0000_0000_0000, 1'b1, 1'b1);
    rst_tb = 1'b0;
    step(1'b0, 64'd0, 1'b1, 1'b1, a);
    step(1'b0, 64'd0, 1'b1, 1'b1, a);
    check("s6_ex_data", 64'(m_ex_data), 64'd0);
    check("s6_ex_zero", 64'(m_ex_zero), 64'd0);
    rst_tb = 1'b1;
    for (int i = 0; i < 4; i++) send(64'h3FF0_0000_0000_0000, 1'b1, 1'b1);
    drain(3);
    check("s6_emax", 64'(last_ex_data), 64'h400);

    // Randomized traffic with independent backpressure on both outputs.
    for (int i = 0; i < 600; i++) begin
      v = rand_value();
      step(($urandom_range(0, 9) < 7), v, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), a);
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
